// File: rtl/rv_fetch_queue.sv
// Instruction fetch unit: sequential PC requests, in-order responses, DEPTH-entry
// decode queue and a FLUSH state that drains stale responses. Optional: FETCH_PERF_EN.
module rv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            o_dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_FETCH = 1'b0, S_FLUSH = 1'b1} state_t;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // a stalled request keeps its address, a stalled head keeps its pc/data.
  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_out_cnt, w_out_next;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_head, r_tail;
  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic [31:0]     r_q_data [DEPTH];

  logic            w_req_valid, w_acc, w_push, w_pop, w_inst_valid;
  logic [CW:0]     w_total;
  logic [XLEN-1:0] w_rsp_pc;

  assign w_total      = {1'b0, r_count} + {1'b0, r_out_cnt};
  assign w_req_valid  = rst_n && (r_state == S_FETCH) && !redirect_valid &&
                        (w_total < (CW+1)'(DEPTH));
  assign w_acc        = w_req_valid && imem_req_ready;
  assign w_inst_valid = (r_count != '0);
  assign w_push       = (r_state == S_FETCH) && imem_rsp_valid && !redirect_valid;
  assign w_pop        = w_inst_valid && inst_ready && !redirect_valid;
  // In FETCH every outstanding request was issued sequentially since the last
  // redirect, so the oldest one sits out_cnt words behind the fetch PC.
  assign w_rsp_pc     = r_pc - (XLEN'(r_out_cnt) << 2);

  always_comb begin
    w_out_next = r_out_cnt;
    if (w_acc)
      w_out_next = w_out_next + CW'(1);
    if (imem_rsp_valid && (r_out_cnt != '0))
      w_out_next = w_out_next - CW'(1);
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_FETCH: if (redirect_valid && (w_out_next != '0)) w_state_n = S_FLUSH;
      S_FLUSH: if (imem_rsp_valid && (r_out_cnt == CW'(1))) w_state_n = S_FETCH;
      default: w_state_n = S_FETCH;
    endcase
  end

  // In FLUSH the outstanding counter doubles as the stale-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_n;
      r_out_cnt <= w_out_next;
      if (redirect_valid)
        r_pc <= redirect_pc;
      else if (w_acc)
        r_pc <= r_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= w_rsp_pc;
      r_q_data[r_tail] <= imem_rsp_data;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = w_inst_valid;
  assign inst_data      = r_q_data[r_head];
  assign inst_pc        = r_q_pc[r_head];
  assign o_dbg_state    = (r_state == S_FLUSH);

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (inst_ready && !w_inst_valid && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: directed scenarios plus randomized traffic checked
// against a program-order model of fetch addresses and consumed instructions.
module tb_rv_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b0;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready = 1'b0;
  logic            dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_stall_cnt;
`endif

  rv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .o_dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] pend_addr[$];   // memory side: accepted, not yet answered
  int          pend_cyc[$];
  logic [31:0] acc_q[$];       // accepted request addresses
  int          acc_cyc[$];
  logic [31:0] exp_q[$];       // consumed instruction PCs
  int          cons_cyc[$];
  logic [31:0] m_fetch_pc;     // model: next address to be requested
  logic [31:0] m_exp_pc;       // model: next PC decode must see
  int          m_stall = 0;
  bit          rsp_en  = 1'b0;
  int          rsp_pct = 100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_cyc.delete(); exp_q.delete(); cons_cyc.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    rsp_en = 1'b0; rsp_pct = 100;
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_state", {63'd0, dbg_state}, 64'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf", {32'd0, perf_stall_cnt}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend_addr.delete(); pend_cyc.delete(); clear_logs();
    m_fetch_pc = RESET_PC; m_exp_pc = RESET_PC; m_stall = 0; cyc = 0;
    #1;
    chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("first_req_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
  endtask

  // One clock cycle: memory answers, observe handshakes, advance the model.
  task automatic step();
    logic        acc, cons, held, req_stall;
    logic [31:0] h_pc, h_data, r_addr;
    if (rsp_en && pend_addr.size() > 0 && pend_cyc[0] < cyc &&
        $urandom_range(0, 99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    acc       = imem_req_valid && imem_req_ready;
    cons      = inst_valid && inst_ready && !redirect_valid;
    held      = inst_valid && !inst_ready && !redirect_valid;
    req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
    h_pc = inst_pc; h_data = inst_data; r_addr = imem_req_addr;
`ifdef FETCH_PERF_EN
    if (inst_ready && !inst_valid) m_stall++;
`endif
    if (redirect_valid)
      chk("no_req_on_redirect", {63'd0, imem_req_valid}, 64'd0);
    if (acc) begin
      chk("req_addr", {32'd0, imem_req_addr}, {32'd0, m_fetch_pc});
      acc_q.push_back(imem_req_addr); acc_cyc.push_back(cyc);
      pend_addr.push_back(imem_req_addr); pend_cyc.push_back(cyc);
      m_fetch_pc = m_fetch_pc + 32'd4;
      chk("outstanding_bound", {63'd0, pend_addr.size() <= DEPTH}, 64'd1);
    end
    if (cons) begin
      chk("inst_pc", {32'd0, inst_pc}, {32'd0, m_exp_pc});
      chk("inst_data", {32'd0, inst_data}, {32'd0, mem_word(m_exp_pc)});
      exp_q.push_back(inst_pc); cons_cyc.push_back(cyc);
      m_exp_pc = m_exp_pc + 32'd4;
    end
    if (imem_rsp_valid) begin
      void'(pend_addr.pop_front()); void'(pend_cyc.pop_front());
    end
    if (redirect_valid) begin
      m_fetch_pc = redirect_pc; m_exp_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (held) begin
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("hold_pc", {32'd0, inst_pc}, {32'd0, h_pc});
      chk("hold_data", {32'd0, inst_data}, {32'd0, h_data});
    end
    if (req_stall)
      chk("req_addr_stable", {32'd0, imem_req_addr}, {32'd0, r_addr});
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic run_until_consumed(input string tag);
    for (int i = 0; i < 60 && exp_q.size() == 0; i++) step();
    chk(tag, {63'd0, exp_q.size() > 0}, 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Streaming with 1-cycle memory latency
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
    repeat (8) step();
    chk("t1_acc0_cycle", 64'(acc_cyc[0]), 64'd0);
    chk("t1_cons_count", {63'd0, exp_q.size() >= 3}, 64'd1);
    chk("t1_pc0", {32'd0, exp_q[0]}, 64'h0);
    chk("t1_pc1", {32'd0, exp_q[1]}, 64'h4);
    chk("t1_pc2", {32'd0, exp_q[2]}, 64'h8);
    chk("t1_first_cons_cycle", 64'(cons_cyc[0]), 64'd2);
    chk("t1_back_to_back", 64'(cons_cyc[2] - cons_cyc[0]), 64'd2);

    // Decode stalled: queue plus outstanding limit to DEPTH requests
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b0;
    repeat (10) step();
    chk("t2_acc_count", 64'(acc_q.size()), 64'd4);
    chk("t2_acc_last", {32'd0, acc_q[3]}, 64'hC);
    chk("t2_req_valid_low", {63'd0, imem_req_valid}, 64'd0);
    chk("t2_head_valid", {63'd0, inst_valid}, 64'd1);
    chk("t2_head_pc", {32'd0, inst_pc}, 64'h0);
    inst_ready = 1'b1;
    repeat (12) step();
    chk("t2_drain_pc3", {32'd0, exp_q[3]}, 64'hC);

    // Redirect with two outstanding requests
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b0; inst_ready = 1'b1;
    repeat (2) step();
    chk("t3_outstanding", 64'(pend_addr.size()), 64'd2);
    redirect_to(32'h100);
    chk("t3_state_flush", {63'd0, dbg_state}, 64'd1);
    chk("t3_no_req_flush", {63'd0, imem_req_valid}, 64'd0);
    clear_logs();
    rsp_en = 1'b1;
    run_until_consumed("t3_timeout");
    chk("t3_first_req", {32'd0, acc_q[0]}, 64'h100);
    chk("t3_first_inst", {32'd0, exp_q[0]}, 64'h100);

    // Second redirect while still flushing: last one wins
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b0; inst_ready = 1'b1;
    repeat (2) step();
    redirect_to(32'h100);
    step();
    redirect_to(32'h200);
    chk("t4_still_flush", {63'd0, dbg_state}, 64'd1);
    clear_logs();
    rsp_en = 1'b1;
    run_until_consumed("t4_timeout");
    chk("t4_first_req", {32'd0, acc_q[0]}, 64'h200);
    chk("t4_first_inst", {32'd0, exp_q[0]}, 64'h200);

    // Fetch PC wraps at the top of the address space
    do_reset();
    imem_req_ready = 1'b0; rsp_en = 1'b1; inst_ready = 1'b1;
    step();
    redirect_to(32'hFFFF_FFFC);
    chk("t5_state_fetch", {63'd0, dbg_state}, 64'd0);
    clear_logs();
    imem_req_ready = 1'b1;
    repeat (6) step();
    chk("t5_req_top", {32'd0, acc_q[0]}, 64'hFFFF_FFFC);
    chk("t5_req_wrap", {32'd0, acc_q[1]}, 64'h0);
    chk("t5_inst_wrap", {32'd0, exp_q[1]}, 64'h0);

`ifdef FETCH_PERF_EN
    // Stall counter: decode ready against an empty queue
    do_reset();
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (3) step();
    inst_ready = 1'b0;
    chk("t6_perf3", {32'd0, perf_stall_cnt}, 64'd3);
    step();
    chk("t6_perf_hold", {32'd0, perf_stall_cnt}, 64'd3);
`endif

    // Randomized traffic against the program-order model
    do_reset();
    rsp_en = 1'b1; rsp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 40) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      step();
      redirect_valid = 1'b0;
    end
`ifdef FETCH_PERF_EN
    chk("rand_perf", {32'd0, perf_stall_cnt}, 64'(m_stall));
`endif
    chk("rand_progress", {63'd0, exp_q.size() > 100}, 64'd1);

    // Reset in the middle of traffic, then resume from RESET_PC
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; rsp_pct = 100; inst_ready = 1'b1;
    run_until_consumed("t8_timeout");
    chk("t8_first_inst", {32'd0, exp_q[0]}, {32'd0, RESET_PC});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
